hx8357_window_fill: RTL and testbench

// - Upstream sequencer for the HX8357 display controller: accepts one rectangle-fill request,

---
 rtl/hx8357_pkg.sv | 34 +++
 rtl/hx8357_window_fill.sv | 219 +++++++++++++++++++++
 tb/tb_hx8357_window_fill.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hx8357_pkg.sv
// Shared opcodes, state encoding and parameter-word helper for the HX8357 window-fill sequencer.
package hx8357_pkg;

  localparam int unsigned RGB565_W = 16;

  localparam logic [15:0] CMD_CASET = 16'h002A;
  localparam logic [15:0] CMD_PASET = 16'h002B;
  localparam logic [15:0] CMD_RAMWR = 16'h002C;

  typedef enum logic [2:0] {
    IDLE,
    CASET_C,
    CASET_P,
    PASET_C,
    PASET_P,
    RAMWR_C,
    PIXELS,
    DONE
  } fill_state_t;

  // Parameter byte idx of {hi(s), lo(s), hi(e), lo(e)}, carried in the low byte.
  function automatic logic [15:0] param_word(input logic [15:0] s, input logic [15:0] e,
                                             input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = {8'h00, s[15:8]};
      2'd1:    w = {8'h00, s[7:0]};
      2'd2:    w = {8'h00, e[15:8]};
      default: w = {8'h00, e[7:0]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hx8357_window_fill.sv
// Rectangle-fill sequencer: emits CASET/PASET/RAMWR then a run of single-colour pixel words
// to the HX8357 controller, one word per transmission_cmpl.
module hx8357_window_fill
  import hx8357_pkg::*;
#(
  parameter int unsigned WIDTH   = 320,
  parameter int unsigned HEIGHT  = 480,
  parameter int unsigned COORD_W = 9,
  parameter int unsigned CNT_W   = 18
) (
  input  logic                clk,
  input  logic                res,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  x1,
  input  logic [COORD_W-1:0]  y0,
  input  logic [COORD_W-1:0]  y1,
  input  logic [RGB565_W-1:0] color,
  input  logic                abort,
  output logic                busy,
  output logic                fill_done,
  output logic                req_err,
  output logic                cmd,
  output logic                data,
  output logic [15:0]         data_in,
  input  logic                transmission_cmpl
);

  fill_state_t          state, state_n;
  logic [1:0]           idx, idx_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]     w_q, w_n, h_q, h_n;
  logic [COORD_W-1:0]   x0_q, x0_n, x1_q, x1_n, y0_q, y0_n, y1_q, y1_n;
  logic [RGB565_W-1:0]  color_q, color_n;
  logic                 abort_q, abort_n;
  logic                 req_ready_n, busy_n, fill_done_n, req_err_n, cmd_n, data_n;
  logic [15:0]          data_in_n;
  logic                 pending, cmpl, abort_now, bad_req;

  assign pending   = cmd | data;
  assign cmpl      = transmission_cmpl & pending;
  assign abort_now = abort_q | abort;
  assign bad_req   = (x0 > x1) || (y0 > y1) || (32'(x1) >= WIDTH) || (32'(y1) >= HEIGHT);

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    w_n         = w_q;
    h_n         = h_q;
    x0_n        = x0_q;
    x1_n        = x1_q;
    y0_n        = y0_q;
    y1_n        = y1_q;
    color_n     = color_q;
    abort_n     = abort_q;
    req_ready_n = req_ready;
    busy_n      = busy;
    fill_done_n = 1'b0;
    req_err_n   = 1'b0;
    cmd_n       = cmd;
    data_n      = data;
    data_in_n   = data_in;

    case (state)
      IDLE: begin
        abort_n     = 1'b0;
        req_ready_n = 1'b1;
        busy_n      = 1'b0;
        if (req_valid && req_ready) begin
          if (bad_req) begin
            req_err_n = 1'b1;
          end else begin
            x0_n        = x0;
            x1_n        = x1;
            y0_n        = y0;
            y1_n        = y1;
            color_n     = color;
            w_n         = CNT_W'(x1) - CNT_W'(x0) + CNT_W'(1);
            h_n         = CNT_W'(y1) - CNT_W'(y0) + CNT_W'(1);
            idx_n       = 2'd0;
            state_n     = CASET_C;
            cmd_n       = 1'b1;
            data_n      = 1'b0;
            data_in_n   = CMD_CASET;
            busy_n      = 1'b1;
            req_ready_n = 1'b0;
          end
        end
      end

      DONE: begin
        state_n     = IDLE;
        abort_n     = 1'b0;
        busy_n      = 1'b0;
        req_ready_n = 1'b1;
      end

      default: begin
        abort_n = abort_now;
        // Pixel count lands one cycle after accept, long before PIXELS is reached.
        if (state == CASET_C) cnt_n = w_q * h_q;

        if (abort_now && (cmpl || !pending)) begin
          state_n     = DONE;
          cmd_n       = 1'b0;
          data_n      = 1'b0;
          fill_done_n = 1'b1;
        end else if (cmpl) begin
          case (state)
            CASET_C: begin
              state_n   = CASET_P;
              cmd_n     = 1'b0;
              data_n    = 1'b1;
              idx_n     = 2'd0;
              data_in_n = param_word(16'(x0_q), 16'(x1_q), 2'd0);
            end
            CASET_P: begin
              if (idx == 2'd3) begin
                state_n   = PASET_C;
                cmd_n     = 1'b1;
                data_n    = 1'b0;
                data_in_n = CMD_PASET;
              end else begin
                idx_n     = idx + 2'd1;
                data_in_n = param_word(16'(x0_q), 16'(x1_q), idx + 2'd1);
              end
            end
            PASET_C: begin
              state_n   = PASET_P;
              cmd_n     = 1'b0;
              data_n    = 1'b1;
              idx_n     = 2'd0;
              data_in_n = param_word(16'(y0_q), 16'(y1_q), 2'd0);
            end
            PASET_P: begin
              if (idx == 2'd3) begin
                state_n   = RAMWR_C;
                cmd_n     = 1'b1;
                data_n    = 1'b0;
                data_in_n = CMD_RAMWR;
              end else begin
                idx_n     = idx + 2'd1;
                data_in_n = param_word(16'(y0_q), 16'(y1_q), idx + 2'd1);
              end
            end
            RAMWR_C: begin
              state_n   = PIXELS;
              cmd_n     = 1'b0;
              data_n    = 1'b1;
              data_in_n = color_q;
            end
            PIXELS: begin
              if (cnt == CNT_W'(1)) begin
                state_n     = DONE;
                cmd_n       = 1'b0;
                data_n      = 1'b0;
                fill_done_n = 1'b1;
              end else begin
                cnt_n = cnt - CNT_W'(1);
              end
            end
            default: begin
              state_n = IDLE;
              cmd_n   = 1'b0;
              data_n  = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      abort_q   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      fill_done <= 1'b0;
      req_err   <= 1'b0;
      cmd       <= 1'b0;
      data      <= 1'b0;
      data_in   <= 16'h0000;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      w_q       <= w_n;
      h_q       <= h_n;
      x0_q      <= x0_n;
      x1_q      <= x1_n;
      y0_q      <= y0_n;
      y1_q      <= y1_n;
      color_q   <= color_n;
      abort_q   <= abort_n;
      req_ready <= req_ready_n;
      busy      <= busy_n;
      fill_done <= fill_done_n;
      req_err   <= req_err_n;
      cmd       <= cmd_n;
      data      <= data_n;
      data_in   <= data_in_n;
    end
  end

endmodule

// File: tb/tb_hx8357_window_fill.sv
// Scoreboard bench for hx8357_window_fill with a controller model that completes each word
// a fixed number of cycles after it appears.
module tb_hx8357_window_fill;
  import hx8357_pkg::*;

  localparam int unsigned COORD_W = 9;
  localparam int unsigned CNT_W   = 18;

  logic               clk = 1'b0;
  logic               res = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [COORD_W-1:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [15:0]        color = '0;
  logic               abort = 1'b0;
  logic               busy, fill_done, req_err, cmd, data;
  logic [15:0]        data_in;
  logic               transmission_cmpl = 1'b0;

  hx8357_window_fill #(.WIDTH(320), .HEIGHT(480), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .abort(abort),
    .busy(busy), .fill_done(fill_done), .req_err(req_err),
    .cmd(cmd), .data(data), .data_in(data_in), .transmission_cmpl(transmission_cmpl)
  );

  always #5 clk = ~clk;

  // kind: 0 command word, 1 data word, 2 fill_done pulse, 3 req_err pulse
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  words_seen = 0;
  int  lat = 3;
  int  wcnt = 0;

  // Controller model: cmpl pulses lat cycles after a word appears
  always @(posedge clk) begin
    if (res) begin
      transmission_cmpl <= 1'b0;
      wcnt <= 0;
    end else if (transmission_cmpl) begin
      transmission_cmpl <= 1'b0;
      wcnt <= 0;
    end else if (cmd | data) begin
      if (wcnt + 1 >= lat) transmission_cmpl <= 1'b1;
      else wcnt <= wcnt + 1;
    end
  end

  task automatic pop_cmp(input logic [1:0] kind, input logic [15:0] val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d val=%h, queue empty", kind, val);
    end else begin
      e = q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        errors++;
        $display("FAIL event_order actual kind=%0d val=%h required kind=%0d val=%h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: samples on the falling edge
  logic        p_pend = 1'b0, p_cmpl = 1'b0, p_cmd = 1'b0, p_data = 1'b0;
  logic [15:0] p_din = '0;
  always @(negedge clk) begin
    if (res) begin
      p_pend = 1'b0;
    end else begin
      if (cmd && data) begin
        checks++;
        errors++;
        $display("FAIL strobe_exclusive actual cmd=1 data=1 required one strobe");
      end
      if (p_pend && !p_cmpl) begin
        checks++;
        if ({cmd, data, data_in} !== {p_cmd, p_data, p_din}) begin
          errors++;
          $display("FAIL word_stable actual %b%b/%h required %b%b/%h",
                   cmd, data, data_in, p_cmd, p_data, p_din);
        end
      end
      if (transmission_cmpl && (cmd | data)) begin
        words_seen++;
        pop_cmp(cmd ? 2'd0 : 2'd1, data_in);
      end
      if (fill_done) pop_cmp(2'd2, 16'h0000);
      if (req_err) pop_cmp(2'd3, 16'h0000);
      p_pend = cmd | data;
    end
    p_cmpl = transmission_cmpl;
    p_cmd  = cmd;
    p_data = data;
    p_din  = data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic push_params(input int s_i, input int e_i);
    logic [15:0] s, e;
    s = 16'(s_i);
    e = 16'(e_i);
    push(2'd1, {8'h00, s[15:8]});
    push(2'd1, {8'h00, s[7:0]});
    push(2'd1, {8'h00, e[15:8]});
    push(2'd1, {8'h00, e[7:0]});
  endtask

  task automatic expect_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [15:0] col, input int npix);
    push(2'd0, 16'h002A);
    push_params(ax0, ax1);
    push(2'd0, 16'h002B);
    push_params(ay0, ay1);
    push(2'd0, 16'h002C);
    for (int i = 0; i < npix; i++) push(2'd1, col);
    push(2'd2, 16'h0000);
  endtask

  // Presents a request for one cycle; returns #1 after the accepting edge
  task automatic issue(input int ax0, input int ax1, input int ay0, input int ay1,
                       input logic [15:0] col);
    @(posedge clk);
    #1;
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    x0 = COORD_W'(ax0);
    x1 = COORD_W'(ax1);
    y0 = COORD_W'(ay0);
    y1 = COORD_W'(ay1);
    color = col;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!(fill_done || req_err) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no completion required=completion within %0d", name, budget);
    end
    @(posedge clk);
    #1;
    chk({name, "_fill_done_single"}, 32'(fill_done), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({name, "_queue_drained"}, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (words_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL word_wait_timeout actual=%0d required=%0d", words_seen, target);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    chk("rst_req_err", 32'(req_err), 32'd0);
    chk("rst_strobes", 32'({cmd, data}), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'h0000);

    // 2x2 fill, first word one cycle after accept
    expect_fill(0, 1, 0, 1, 16'hF800, 4);
    issue(0, 1, 0, 1, 16'hF800);
    chk("t1_first_cmd", 32'({cmd, data}), 32'b10);
    chk("t1_first_word", 32'(data_in), 32'h002A);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_low", 32'(req_ready), 32'd0);
    wait_end("t1", 500);

    // Right/bottom band, fast controller
    lat = 1;
    expect_fill(256, 319, 300, 479, 16'h07E0, 11520);
    issue(256, 319, 300, 479, 16'h07E0);
    wait_end("t2", 30000);
    lat = 3;

    // Rejected requests, including one-past-edge coordinates
    for (int k = 0; k < 4; k++) begin
      int a0, a1, b0, b1;
      a0 = 0; a1 = 10; b0 = 0; b1 = 10;
      case (k)
        0: begin a0 = 5; a1 = 4; end
        1: begin b0 = 9; b1 = 8; end
        2: a1 = 320;
        default: b1 = 480;
      endcase
      push(2'd3, 16'h0000);
      issue(a0, a1, b0, b1, 16'h1234);
      chk("t3_req_err_pulse", 32'(req_err), 32'd1);
      chk("t3_busy_low", 32'(busy), 32'd0);
      chk("t3_no_strobe", 32'({cmd, data}), 32'd0);
      chk("t3_ready_high", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("t3_req_err_single", 32'(req_err), 32'd0);
      chk("t3_queue_drained", 32'(q.size()), 32'd0);
    end

    // Full panel: pixel counter loads 153600, then abort after the first pixel
    expect_fill(0, 319, 0, 479, 16'h001F, 1);
    base = words_seen;
    issue(0, 319, 0, 479, 16'h001F);
    wait_words(base + 11, 500);
    #1;
    chk("t4_pixel_count", 32'(dut.cnt), 32'd153600);
    chk("t4_pixel_word", 32'(data_in), 32'h001F);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_end("t4", 500);

    // Abort during pixel word 2 of 10
    expect_fill(0, 4, 0, 1, 16'hABCD, 2);
    base = words_seen;
    issue(0, 4, 0, 1, 16'hABCD);
    wait_words(base + 12, 500);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_end("t5", 500);

    // Abort while idle is ignored; 1x1 fill at the far corner
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    expect_fill(319, 319, 479, 479, 16'h5A5A, 1);
    issue(319, 319, 479, 479, 16'h5A5A);
    wait_end("t_min", 500);

    // Reset in PASET_P, then a clean fill
    expect_fill(0, 1, 0, 1, 16'h0F0F, 4);
    base = words_seen;
    issue(0, 1, 0, 1, 16'h0F0F);
    wait_words(base + 6, 500);
    #1;
    chk("t6_in_paset_p", 32'({cmd, data}), 32'b01);
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    chk("t6_strobes_cleared", 32'({cmd, data}), 32'd0);
    chk("t6_busy_cleared", 32'(busy), 32'd0);
    chk("t6_ready_set", 32'(req_ready), 32'd1);
    chk("t6_no_fill_done", 32'(fill_done), 32'd0);
    q.delete();
    expect_fill(2, 3, 4, 5, 16'hF800, 4);
    issue(2, 3, 4, 5, 16'hF800);
    chk("t6_restart_caset", 32'(data_in), 32'h002A);
    wait_end("t6", 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
